// File: rtl/cache_ctrl_pkg.sv
// Shared types for the MESI L1 cache controller: bus/xbar message formats,
// line state encoding and system-wide sizing constants.
package cache_ctrl_pkg;

  localparam int XLEN           = 32;
  localparam int CACHELINE_SIZE = 32;
  localparam int NUM_CPUS       = 2;
  // Destination field must also encode the memory endpoint (index NUM_CPUS).
  localparam int CPU_W          = $clog2(NUM_CPUS + 1);
  localparam logic [CPU_W-1:0] MEM_DEST = CPU_W'(NUM_CPUS);

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_state_t;

  typedef struct packed {
    logic             valid;
    bus_op_t          op;
    logic [XLEN-1:0]  addr;
    logic [CPU_W-1:0] source;
  } bus_msg_t;

  typedef struct packed {
    logic                      valid;
    logic [XLEN-1:0]           addr;
    logic [CACHELINE_SIZE-1:0] data;
    logic [CPU_W-1:0]          destination;
  } xbar_msg_t;

endpackage

// File: rtl/cache_ctrl_array.sv
// Direct-mapped tag/state/data storage. Two asynchronous read ports (CPU
// lookup and snoop) and a write port pair: the snoop path only updates line
// state, the FSM path rewrites a whole line. When both hit the same set the
// FSM write is applied last; the FSM has already folded the snoop outcome in.
module cache_array
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_SETS = 4,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int TAG_W = XLEN - IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDX_W-1:0]          lk_idx,
  output mesi_state_t               lk_state,
  output logic [TAG_W-1:0]          lk_tag,
  output logic [CACHELINE_SIZE-1:0] lk_data,
  input  logic [IDX_W-1:0]          sn_idx,
  output mesi_state_t               sn_state,
  output logic [TAG_W-1:0]          sn_tag,
  output logic [CACHELINE_SIZE-1:0] sn_data,
  input  logic                      sn_we,
  input  mesi_state_t               sn_wr_state,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  mesi_state_t               wr_state,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic [CACHELINE_SIZE-1:0] wr_data
);

  mesi_state_t               state_q [NUM_SETS];
  mesi_state_t               state_d [NUM_SETS];
  logic [TAG_W-1:0]          tag_q   [NUM_SETS];
  logic [TAG_W-1:0]          tag_d   [NUM_SETS];
  logic [CACHELINE_SIZE-1:0] data_q  [NUM_SETS];
  logic [CACHELINE_SIZE-1:0] data_d  [NUM_SETS];

  assign lk_state = state_q[lk_idx];
  assign lk_tag   = tag_q[lk_idx];
  assign lk_data  = data_q[lk_idx];
  assign sn_state = state_q[sn_idx];
  assign sn_tag   = tag_q[sn_idx];
  assign sn_data  = data_q[sn_idx];

  // Next array contents: snoop state update first, FSM line write on top.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (sn_we) state_d[sn_idx] = sn_wr_state;
    if (wr_en) begin
      state_d[wr_idx] = wr_state;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  // Array registers; reset leaves every line invalid and zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        state_q[i] <= MESI_I;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Per-CPU MESI L1 controller: serves CPU line loads/stores from a
// direct-mapped array, initiates Bus_Rd/RdX/Upgr/WB, consumes xbar fills,
// and snoops other CPUs' bus traffic (downgrade/invalidate, dirty supply).
// Handshakes: a CPU request is accepted on a cycle with cpu_req_valid and
// cpu_req_ready both high; bus_req is held until the one-cycle bus_gnt, and
// bus_out is valid only in that grant cycle.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int CPU_ID   = 0,
  parameter int NUM_SETS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid,
  input  logic                      cpu_req_we,
  input  logic [XLEN-1:0]           cpu_req_addr,
  input  logic [CACHELINE_SIZE-1:0] cpu_req_wdata,
  output logic                      cpu_req_ready,
  output logic                      cpu_resp_valid,
  output logic [CACHELINE_SIZE-1:0] cpu_resp_rdata,
  output logic                      bus_req,
  input  logic                      bus_gnt,
  output bus_msg_t                  bus_out,
  input  bus_msg_t                  bus_msg,
  output logic                      snoop_shared,
  output logic                      snoop_dirty,
  input  logic                      bus_shared,
  input  xbar_msg_t                 xbar_in,
  output xbar_msg_t                 xbar_out
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = XLEN - IDX_W;
  localparam logic [CPU_W-1:0] MY_ID = CPU_W'(CPU_ID);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WB_REQ    = 3'd1;
  localparam logic [2:0] MISS_REQ  = 3'd2;
  localparam logic [2:0] WAIT_DATA = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [XLEN-1:0]           req_addr_q, req_addr_d;
  logic                      req_we_q, req_we_d;
  logic [CACHELINE_SIZE-1:0] req_wdata_q, req_wdata_d;
  bus_op_t                   op_q, op_d;
  logic                      shared_q, shared_d;
  logic [CACHELINE_SIZE-1:0] resp_data_q, resp_data_d;
  xbar_msg_t                 supply_q, supply_d;
  xbar_msg_t                 wb_pend_q, wb_pend_d;

  logic [IDX_W-1:0]          lk_idx, sn_idx;
  mesi_state_t               lk_state, sn_state, sn_next, eff_state, wr_state;
  logic [TAG_W-1:0]          lk_tag, sn_tag, wr_tag, cpu_tag, req_tag, bus_tag;
  logic [CACHELINE_SIZE-1:0] lk_data, sn_data, wr_data;
  logic                      wr_en, sn_hit, sn_we, sn_supply, sn_req_line, wb_now;
  xbar_msg_t                 wb_msg;

  assign cpu_tag = cpu_req_addr[XLEN-1:IDX_W];
  assign req_tag = req_addr_q[XLEN-1:IDX_W];
  assign bus_tag = bus_msg.addr[XLEN-1:IDX_W];
  assign sn_idx  = bus_msg.addr[IDX_W-1:0];
  assign lk_idx  = (state_q == IDLE) ? cpu_req_addr[IDX_W-1:0] : req_addr_q[IDX_W-1:0];

  cache_array #(.NUM_SETS(NUM_SETS)) u_array (
    .clk         (clk),
    .rst         (rst),
    .lk_idx      (lk_idx),
    .lk_state    (lk_state),
    .lk_tag      (lk_tag),
    .lk_data     (lk_data),
    .sn_idx      (sn_idx),
    .sn_state    (sn_state),
    .sn_tag      (sn_tag),
    .sn_data     (sn_data),
    .sn_we       (sn_we),
    .sn_wr_state (sn_next),
    .wr_en       (wr_en),
    .wr_idx      (lk_idx),
    .wr_state    (wr_state),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data)
  );

  // Snoop decode: foreign transaction hitting a valid line here.
  always_comb begin
    sn_hit    = bus_msg.valid && (bus_msg.source != MY_ID) &&
                (sn_state != MESI_I) && (sn_tag == bus_tag);
    sn_next   = sn_state;
    sn_supply = 1'b0;
    if (sn_hit) begin
      case (bus_msg.op)
        BUS_RD: begin
          if (sn_state == MESI_M || sn_state == MESI_E) sn_next = MESI_S;
          sn_supply = (sn_state == MESI_M);
        end
        BUS_RDX: begin
          sn_next   = MESI_I;
          sn_supply = (sn_state == MESI_M);
        end
        BUS_UPGR: if (sn_state == MESI_S) sn_next = MESI_I;
        default: ;
      endcase
    end
    sn_we       = sn_hit && (sn_next != sn_state);
    // A snoop changing the set the FSM is working on this cycle.
    sn_req_line = sn_we && (sn_idx == lk_idx);
  end

  assign snoop_shared = sn_hit;
  assign snoop_dirty  = sn_supply;

  // Main FSM: lookup, bus requests, fill install and CPU response.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    op_d        = op_q;
    shared_d    = shared_q;
    resp_data_d = resp_data_q;
    wr_en       = 1'b0;
    wr_state    = lk_state;
    wr_tag      = lk_tag;
    wr_data     = lk_data;
    bus_req     = 1'b0;
    bus_out     = '0;
    wb_now      = 1'b0;
    wb_msg      = '0;
    // Lookup sees the line as it will be after a same-cycle snoop.
    eff_state   = sn_req_line ? sn_next : lk_state;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          req_addr_d  = cpu_req_addr;
          req_we_d    = cpu_req_we;
          req_wdata_d = cpu_req_wdata;
          if (eff_state != MESI_I && lk_tag == cpu_tag) begin
            if (!cpu_req_we) begin
              resp_data_d = lk_data;
              state_d     = RESP;
            end else if (eff_state == MESI_M || eff_state == MESI_E) begin
              wr_en       = 1'b1;
              wr_state    = MESI_M;
              wr_data     = cpu_req_wdata;
              resp_data_d = '0;
              state_d     = RESP;
            end else begin
              op_d    = BUS_UPGR;
              state_d = MISS_REQ;
            end
          end else begin
            op_d    = cpu_req_we ? BUS_RDX : BUS_RD;
            state_d = (eff_state == MESI_M) ? WB_REQ : MISS_REQ;
          end
        end
      end
      WB_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          bus_out.valid      = 1'b1;
          bus_out.op         = BUS_WB;
          bus_out.addr       = {lk_tag, lk_idx};
          bus_out.source     = MY_ID;
          wb_now             = 1'b1;
          wb_msg.valid       = 1'b1;
          wb_msg.addr        = {lk_tag, lk_idx};
          wb_msg.data        = lk_data;
          wb_msg.destination = MEM_DEST;
          wr_en              = 1'b1;
          wr_state           = MESI_I;
          state_d            = MISS_REQ;
        end else if (sn_req_line) begin
          // Victim already downgraded/supplied by a snoop: nothing to write back.
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          bus_out.valid  = 1'b1;
          bus_out.op     = op_q;
          bus_out.addr   = req_addr_q;
          bus_out.source = MY_ID;
          if (op_q == BUS_UPGR) begin
            wr_en       = 1'b1;
            wr_state    = MESI_M;
            wr_tag      = req_tag;
            wr_data     = req_wdata_q;
            resp_data_d = '0;
            state_d     = RESP;
          end else begin
            shared_d = bus_shared;
            state_d  = WAIT_DATA;
          end
        end else if (op_q == BUS_UPGR && sn_req_line) begin
          // Our S copy was invalidated first; we now need the data too.
          op_d = BUS_RDX;
        end
      end
      WAIT_DATA: begin
        if (xbar_in.valid && xbar_in.destination == MY_ID && xbar_in.addr == req_addr_q) begin
          wr_en       = 1'b1;
          wr_tag      = req_tag;
          wr_state    = req_we_q ? MESI_M : (shared_q ? MESI_S : MESI_E);
          wr_data     = req_we_q ? req_wdata_q : xbar_in.data;
          resp_data_d = req_we_q ? '0 : xbar_in.data;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outgoing xbar data: snoop supply is registered; a writeback goes out in
  // its grant cycle unless a supply owns the port, then it follows one cycle on.
  always_comb begin
    supply_d = '0;
    if (sn_supply) begin
      supply_d.valid       = 1'b1;
      supply_d.addr        = bus_msg.addr;
      supply_d.data        = sn_data;
      supply_d.destination = bus_msg.source;
    end
    wb_pend_d = (wb_now && supply_q.valid) ? wb_msg : '0;
    xbar_out  = supply_q.valid ? supply_q : (wb_now ? wb_msg : wb_pend_q);
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == RESP);
  assign cpu_resp_rdata = resp_data_q;

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      op_q        <= BUS_RD;
      shared_q    <= 1'b0;
      resp_data_q <= '0;
      supply_q    <= '0;
      wb_pend_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      op_q        <= op_d;
      shared_q    <= shared_d;
      resp_data_q <= resp_data_d;
      supply_q    <= supply_d;
      wb_pend_q   <= wb_pend_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl (CPU 0). The bench plays CPU 1, the bus
// arbiter and memory; expected responses/bus/xbar messages are queued when
// stimulus is issued and a negedge monitor pops and compares them.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  localparam int BUS_W  = $bits(bus_msg_t);
  localparam int XBAR_W = $bits(xbar_msg_t);

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      cpu_req_valid, cpu_req_we;
  logic [XLEN-1:0]           cpu_req_addr;
  logic [CACHELINE_SIZE-1:0] cpu_req_wdata;
  logic                      cpu_req_ready, cpu_resp_valid;
  logic [CACHELINE_SIZE-1:0] cpu_resp_rdata;
  logic                      bus_req, bus_gnt, bus_shared;
  logic                      snoop_shared, snoop_dirty;
  bus_msg_t                  bus_out, bus_msg;
  xbar_msg_t                 xbar_in, xbar_out;

  cache_ctrl #(.CPU_ID(0), .NUM_SETS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .bus_req        (bus_req),
    .bus_gnt        (bus_gnt),
    .bus_out        (bus_out),
    .bus_msg        (bus_msg),
    .snoop_shared   (snoop_shared),
    .snoop_dirty    (snoop_dirty),
    .bus_shared     (bus_shared),
    .xbar_in        (xbar_in),
    .xbar_out       (xbar_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [CACHELINE_SIZE-1:0] exp_resp_q[$];
  logic [BUS_W-1:0]          exp_bus_q[$];
  logic [XBAR_W-1:0]         exp_xbar_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic bus_msg_t mk_bus(input bus_op_t op, input logic [XLEN-1:0] a,
                                      input logic [CPU_W-1:0] src);
    bus_msg_t m;
    m.valid = 1'b1; m.op = op; m.addr = a; m.source = src;
    return m;
  endfunction

  function automatic xbar_msg_t mk_xbar(input logic [XLEN-1:0] a, input logic [CACHELINE_SIZE-1:0] d,
                                        input logic [CPU_W-1:0] dst);
    xbar_msg_t m;
    m.valid = 1'b1; m.addr = a; m.data = d; m.destination = dst;
    return m;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (cpu_resp_valid) begin
        if (exp_resp_q.size() == 0) fail_now("unexpected cpu_resp");
        else chk("cpu_resp_rdata", cpu_resp_rdata, exp_resp_q.pop_front());
      end
      if (bus_out.valid) begin
        if (exp_bus_q.size() == 0) fail_now("unexpected bus_out");
        else chk("bus_out", bus_out, exp_bus_q.pop_front());
      end
      if (xbar_out.valid) begin
        if (exp_xbar_q.size() == 0) fail_now("unexpected xbar_out");
        else chk("xbar_out", xbar_out, exp_xbar_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_op(input logic we, input logic [XLEN-1:0] a,
                        input logic [CACHELINE_SIZE-1:0] wd, input bit local_done);
    int n = 0;
    tick();
    while (!cpu_req_ready && n < 20) begin tick(); n++; end
    if (!cpu_req_ready) begin fail_now("cpu_req_ready timeout"); return; end
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = wd;
    tick();
    cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("resp_after_accept", cpu_resp_valid, local_done);
    chk("bus_req_after_accept", bus_req, !local_done);
  endtask

  task automatic grant(input bus_op_t op, input logic [XLEN-1:0] a, input bit shared, input bit done);
    int n = 0;
    tick();
    while (!bus_req && n < 20) begin tick(); n++; end
    if (!bus_req) begin fail_now("bus_req timeout"); return; end
    exp_bus_q.push_back(mk_bus(op, a, 2'd0));
    bus_gnt = 1'b1; bus_msg = mk_bus(op, a, 2'd0); bus_shared = shared;
    tick();
    bus_gnt = 1'b0; bus_msg = '0; bus_shared = 1'b0;
    @(negedge clk);
    chk("resp_after_grant", cpu_resp_valid, done);
  endtask

  task automatic fill(input logic [XLEN-1:0] a, input logic [CACHELINE_SIZE-1:0] d,
                      input logic [CPU_W-1:0] dst, input bit done);
    tick();
    xbar_in = mk_xbar(a, d, dst);
    tick();
    xbar_in = '0;
    @(negedge clk);
    chk("resp_after_fill", cpu_resp_valid, done);
  endtask

  task automatic snoop(input bus_op_t op, input logic [XLEN-1:0] a,
                       input bit e_shared, input bit e_dirty, input bit e_supply);
    tick();
    bus_msg = mk_bus(op, a, 2'd1);
    @(negedge clk);
    chk("snoop_shared", snoop_shared, e_shared);
    chk("snoop_dirty", snoop_dirty, e_dirty);
    tick();
    bus_msg = '0;
    @(negedge clk);
    chk("supply_valid", xbar_out.valid, e_supply);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ready"}, cpu_req_ready, 1'b1);
    chk({tag, " bus_req"}, bus_req, 1'b0);
    chk({tag, " bus_out"}, bus_out, '0);
    chk({tag, " xbar_out"}, xbar_out, '0);
    chk({tag, " resp_valid"}, cpu_resp_valid, 1'b0);
    chk({tag, " resp_rdata"}, cpu_resp_rdata, '0);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    bus_gnt = 1'b0; bus_shared = 1'b0; bus_msg = '0; xbar_in = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    mon_en = 1'b1;

    // Cold load 0x5, exclusive fill; stray fills must be ignored.
    cpu_op(1'b0, 32'h5, '0, 1'b0);
    grant(BUS_RD, 32'h5, 1'b0, 1'b0);
    fill(32'h5, 32'hDEAD, 2'd1, 1'b0);
    fill(32'h6, 32'hBEEF, 2'd0, 1'b0);
    exp_resp_q.push_back(32'h5);
    fill(32'h5, 32'h5, 2'd0, 1'b1);
    // Repeat load hits.
    exp_resp_q.push_back(32'h5);
    cpu_op(1'b0, 32'h5, '0, 1'b1);
    // Store on E: silent upgrade to M.
    exp_resp_q.push_back(32'h0);
    cpu_op(1'b1, 32'h5, 32'hAA, 1'b1);
    // Foreign Bus_Rd: dirty supply, line -> S.
    exp_xbar_q.push_back(mk_xbar(32'h5, 32'hAA, 2'd1));
    snoop(BUS_RD, 32'h5, 1'b1, 1'b1, 1'b1);
    // Store on S: Bus_Upgr, resp right after grant.
    cpu_op(1'b1, 32'h5, 32'hBB, 1'b0);
    exp_resp_q.push_back(32'h0);
    grant(BUS_UPGR, 32'h5, 1'b0, 1'b1);
    // Foreign Bus_RdX: supply, line -> I.
    exp_xbar_q.push_back(mk_xbar(32'h5, 32'hBB, 2'd1));
    snoop(BUS_RDX, 32'h5, 1'b1, 1'b1, 1'b1);
    // Reload with bus_shared -> S; foreign Rd sees shared but clean.
    cpu_op(1'b0, 32'h5, '0, 1'b0);
    grant(BUS_RD, 32'h5, 1'b1, 1'b0);
    exp_resp_q.push_back(32'h77);
    fill(32'h5, 32'h77, 2'd0, 1'b1);
    snoop(BUS_RD, 32'h5, 1'b1, 1'b0, 1'b0);
    // Upgrade race: foreign Upgr lands first, ours becomes RdX.
    cpu_op(1'b1, 32'h5, 32'hCC, 1'b0);
    snoop(BUS_UPGR, 32'h5, 1'b1, 1'b0, 1'b0);
    grant(BUS_RDX, 32'h5, 1'b0, 1'b0);
    exp_resp_q.push_back(32'h0);
    fill(32'h5, 32'h99, 2'd0, 1'b1);
    // Conflict miss on M victim: writeback to memory, then Bus_Rd.
    cpu_op(1'b0, 32'h9, '0, 1'b0);
    exp_xbar_q.push_back(mk_xbar(32'h5, 32'hCC, MEM_DEST));
    grant(BUS_WB, 32'h5, 1'b0, 1'b0);
    grant(BUS_RD, 32'h9, 1'b0, 1'b0);
    exp_resp_q.push_back(32'h1234);
    fill(32'h9, 32'h1234, 2'd0, 1'b1);
    exp_resp_q.push_back(32'h0);
    cpu_op(1'b1, 32'h9, 32'hDD, 1'b1);
    snoop(BUS_RD, 32'h5, 1'b0, 1'b0, 1'b0);
    // Victim race: snoop downgrades the M victim before grant; no writeback.
    cpu_op(1'b0, 32'hD, '0, 1'b0);
    exp_xbar_q.push_back(mk_xbar(32'h9, 32'hDD, 2'd1));
    snoop(BUS_RD, 32'h9, 1'b1, 1'b1, 1'b1);
    grant(BUS_RD, 32'hD, 1'b0, 1'b0);
    exp_resp_q.push_back(32'h55);
    fill(32'hD, 32'h55, 2'd0, 1'b1);
    // Reset while waiting for data.
    cpu_op(1'b0, 32'h2, '0, 1'b0);
    grant(BUS_RD, 32'h2, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("mid_reset");
    cpu_op(1'b0, 32'h5, '0, 1'b0);
    grant(BUS_RD, 32'h5, 1'b0, 1'b0);
    exp_resp_q.push_back(32'h42);
    fill(32'h5, 32'h42, 2'd0, 1'b1);

    tick(); tick();
    chk("resp_q_drained", exp_resp_q.size(), 0);
    chk("bus_q_drained", exp_bus_q.size(), 0);
    chk("xbar_q_drained", exp_xbar_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
